// File: rtl/audio_voice_mixer.sv
// 48 kHz sample sequencer for the I2S path: polls voice generators each tick,
// pans, sums, saturates and latches one byte-swapped left/right pair.
module audio_voice_mixer #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned TICK_INC   = 48000,
  parameter int unsigned TICK_MOD   = 74250000,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                      clk_74a,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NUM_VOICES-1:0]     voice_enable,
  input  logic [NUM_VOICES-1:0]     pan_left,
  input  logic [NUM_VOICES-1:0]     pan_right,
  output logic [NUM_VOICES-1:0]     voice_req,
  input  logic [NUM_VOICES-1:0]     voice_ack,
  input  logic [16*NUM_VOICES-1:0]  voice_data,
  input  logic                      clear_flags,
  output logic [15:0]               left_audio,
  output logic [15:0]               right_audio,
  output logic                      sample_strobe,
  output logic                      overrun,
  output logic                      timeout_flag
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned ACC_W = 19;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, SAT} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [TMR_W-1:0]         timer;
  logic signed [ACC_W-1:0]  acc_l;
  logic signed [ACC_W-1:0]  acc_r;
  logic [31:0]              phase;
  logic                     tick;

  logic [32:0]              phase_sum_c;
  logic                     tick_hit_c;
  logic [15:0]              cur_data_c;
  logic signed [ACC_W-1:0]  cur_ext_c;
  logic                     cur_ack_c;
  logic                     timer_done_c;
  logic                     last_c;

  // Phase accumulator: one registered tick per TICK_MOD/TICK_INC clocks on average
  assign phase_sum_c = {1'b0, phase} + 33'(TICK_INC);
  assign tick_hit_c  = (phase_sum_c >= 33'(TICK_MOD));

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      tick  <= 1'b0;
    end else begin
      phase <= tick_hit_c ? 32'(phase_sum_c - 33'(TICK_MOD)) : phase_sum_c[31:0];
      tick  <= tick_hit_c;
    end
  end

  assign cur_data_c   = voice_data[{idx, 4'b0000} +: 16];
  assign cur_ext_c    = ACC_W'($signed(cur_data_c));
  assign cur_ack_c    = voice_ack[idx] & voice_req[idx];
  assign timer_done_c = (timer == TMR_LAST);
  assign last_c       = (idx == LAST_IDX);

  // Clamp to 16-bit signed, then swap bytes for the serializer
  function automatic logic [15:0] sat_swap(input logic signed [ACC_W-1:0] a);
    logic [15:0] s;
    if (a > 19'sd32767)       s = 16'h7FFF;
    else if (a < -19'sd32768) s = 16'h8000;
    else                      s = a[15:0];
    return {s[7:0], s[15:8]};
  endfunction

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      idx           <= '0;
      timer         <= '0;
      acc_l         <= '0;
      acc_r         <= '0;
      voice_req     <= '0;
      left_audio    <= '0;
      right_audio   <= '0;
      sample_strobe <= 1'b0;
      overrun       <= 1'b0;
      timeout_flag  <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      if (clear_flags) begin
        overrun      <= 1'b0;
        timeout_flag <= 1'b0;
      end
      // A tick outside IDLE is dropped; later assignment lets set beat clear
      if (tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (tick) begin
            acc_l <= '0;
            acc_r <= '0;
            idx   <= '0;
            state <= enable ? SCAN : SAT;
          end
        end
        SCAN: begin
          if (voice_enable[idx]) begin
            voice_req      <= '0;
            voice_req[idx] <= 1'b1;
            timer          <= '0;
            state          <= WAIT;
          end else if (last_c) begin
            state <= SAT;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= SCAN;
          end
        end
        WAIT: begin
          if (cur_ack_c || timer_done_c) begin
            if (cur_ack_c) begin
              if (pan_left[idx])  acc_l <= acc_l + cur_ext_c;
              if (pan_right[idx]) acc_r <= acc_r + cur_ext_c;
            end else begin
              timeout_flag <= 1'b1;
            end
            voice_req <= '0;
            if (last_c) begin
              state <= SAT;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= SCAN;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        SAT: begin
          left_audio    <= sat_swap(acc_l);
          right_audio   <= sat_swap(acc_r);
          sample_strobe <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_voice_mixer.sv
// Directed bench for audio_voice_mixer: a fast-tick main instance with a
// scoreboard, plus small instances for tick rate and overrun behaviour.
module tb_audio_voice_mixer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Main instance (tick every 400 clocks)
  logic        en_a, clr_a;
  logic [3:0]  ven_a, pl_a, pr_a, req_a;
  logic [3:0]  ack_a = 4'b0000;
  logic [63:0] data_a;
  logic [15:0] l_a, r_a;
  logic        stb_a, ovr_a, to_a;

  // Tick-rate instance (3/64) and overrun instance (1/20)
  logic [3:0]  req_b;
  logic [15:0] l_b, r_b;
  logic        stb_b, ovr_b, to_b;
  logic [1:0]  req_c;
  logic [15:0] l_c, r_c;
  logic        stb_c, ovr_c, to_c;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb_q[$];
  logic        exp_to;
  int          dly[4];
  int          cnt[4] = '{default: 0};
  logic [3:0]  stray;
  int          req_cyc[4];
  logic [3:0]  first_req;

  audio_voice_mixer #(.NUM_VOICES(4), .TICK_INC(1), .TICK_MOD(400), .TIMEOUT(64)) dut_a (
    .clk_74a(clk), .reset_n(reset_n), .enable(en_a), .voice_enable(ven_a),
    .pan_left(pl_a), .pan_right(pr_a), .voice_req(req_a), .voice_ack(ack_a),
    .voice_data(data_a), .clear_flags(clr_a), .left_audio(l_a), .right_audio(r_a),
    .sample_strobe(stb_a), .overrun(ovr_a), .timeout_flag(to_a));

  audio_voice_mixer #(.NUM_VOICES(4), .TICK_INC(3), .TICK_MOD(64), .TIMEOUT(64)) dut_b (
    .clk_74a(clk), .reset_n(reset_n), .enable(1'b1), .voice_enable(4'b0000),
    .pan_left(4'b1111), .pan_right(4'b1111), .voice_req(req_b), .voice_ack(4'b0000),
    .voice_data(64'h0), .clear_flags(1'b0), .left_audio(l_b), .right_audio(r_b),
    .sample_strobe(stb_b), .overrun(ovr_b), .timeout_flag(to_b));

  audio_voice_mixer #(.NUM_VOICES(2), .TICK_INC(1), .TICK_MOD(20), .TIMEOUT(64)) dut_c (
    .clk_74a(clk), .reset_n(reset_n), .enable(1'b1), .voice_enable(2'b01),
    .pan_left(2'b01), .pan_right(2'b00), .voice_req(req_c), .voice_ack(2'b00),
    .voice_data(32'h0000_1234), .clear_flags(1'b0), .left_audio(l_c), .right_audio(r_c),
    .sample_strobe(stb_c), .overrun(ovr_c), .timeout_flag(to_c));

  // Voice generators: ack dly[i] cycles after req rises (0 = never); stray acks ignore req
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req_a[i]) begin
        cnt[i]   = cnt[i] + 1;
        ack_a[i] = ((dly[i] != 0) && (cnt[i] == dly[i])) || stray[i];
      end else begin
        cnt[i]   = 0;
        ack_a[i] = stray[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] swp(input int s);
    logic [15:0] v;
    if (s > 32767)       v = 16'h7FFF;
    else if (s < -32768) v = 16'h8000;
    else                 v = 16'(s);
    return {v[7:0], v[15:8]};
  endfunction

  // Predict the frame from the current configuration, then wait for the strobe and compare
  task automatic run_frame(input string tag);
    int          sl, sr;
    logic        tmo;
    logic [15:0] d;
    logic [31:0] exp;
    bit          got;
    sl = 0; sr = 0; tmo = 1'b0;
    if (en_a) begin
      for (int i = 0; i < 4; i++) begin
        if (ven_a[i]) begin
          if (dly[i] >= 1 && dly[i] <= 64) begin
            d = data_a[16*i +: 16];
            if (pl_a[i]) sl += int'($signed(d));
            if (pr_a[i]) sr += int'($signed(d));
          end else begin
            tmo = 1'b1;
          end
        end
      end
    end
    sb_q.push_back({swp(sl), swp(sr)});
    exp_to = exp_to | tmo;
    for (int i = 0; i < 4; i++) req_cyc[i] = 0;
    first_req = 4'b0000;
    got = 1'b0;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (req_a[i]) req_cyc[i]++;
      if (first_req == 4'b0000 && req_a != 4'b0000) first_req = req_a;
      if (stb_a) got = 1'b1;
    end
    check({tag, "_strobe"}, 32'(got), 32'd1);
    exp = sb_q.pop_front();
    check({tag, "_left"},  32'(l_a), 32'(exp[31:16]));
    check({tag, "_right"}, 32'(r_a), 32'(exp[15:0]));
    check({tag, "_tmo"},   32'(to_a), 32'(exp_to));
  endtask

  initial begin
    int   strobes_b, c_rises, c_run, c_stb;
    logic prev_c, c_ovr, c_to;
    logic [15:0] c_l;
    bit   got;

    reset_n = 1'b0; en_a = 1'b0; clr_a = 1'b0; ven_a = '0; pl_a = '0; pr_a = '0;
    data_a = '0; stray = '0; exp_to = 1'b0;
    for (int i = 0; i < 4; i++) dly[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_left",   32'(l_a), 32'h0);
    check("rst_right",  32'(r_a), 32'h0);
    check("rst_strobe", 32'(stb_a), 32'h0);
    check("rst_req",    32'(req_a), 32'h0);
    check("rst_ovr",    32'(ovr_a), 32'h0);
    check("rst_tmo",    32'(to_a), 32'h0);
    reset_n = 1'b1;

    // Tick rate on dut_b and overrun behaviour on dut_c over the same window
    strobes_b = 0; c_rises = 0; c_run = 0; c_stb = 0; prev_c = 1'b0;
    c_ovr = 1'b0; c_to = 1'b0; c_l = 16'hFFFF;
    repeat (650) begin
      @(negedge clk);
      if (stb_b) strobes_b++;
      if (req_c[0] && !prev_c) c_rises++;
      prev_c = req_c[0];
      if (c_rises == 1 && req_c[0]) c_run++;
      if (stb_c && c_rises == 1) begin
        c_stb++;
        if (c_stb == 1) begin c_ovr = ovr_c; c_to = to_c; c_l = l_c; end
      end
    end
    check("rate_strobes", 32'(strobes_b), 32'd30);
    check("rate_no_ovr",  32'(ovr_b), 32'd0);
    check("ovr_req_len",  32'(c_run), 32'd64);
    check("ovr_one_upd",  32'(c_stb), 32'd1);
    check("ovr_flag",     32'(c_ovr), 32'd1);
    check("ovr_tmo",      32'(c_to), 32'd1);
    check("ovr_left",     32'(c_l), 32'h0);

    // Basic pan/mix
    en_a = 1'b1; ven_a = 4'b0011; pl_a = 4'b0011; pr_a = 4'b0010;
    data_a = {16'h0, 16'h0, 16'h0200, 16'h1000}; dly = '{2, 2, 0, 0};
    run_frame("basic");
    check("basic_left_const",  32'(l_a), 32'h0012);
    check("basic_right_const", 32'(r_a), 32'h0002);

    // Positive and negative saturation
    ven_a = 4'b1111; pl_a = 4'b1111; pr_a = 4'b0000;
    data_a = {4{16'h7000}}; dly = '{1, 1, 1, 1};
    run_frame("sat_pos");
    check("sat_pos_const", 32'(l_a), 32'hFF7F);
    pr_a = 4'b1111; data_a = {4{16'h8000}};
    run_frame("sat_neg");
    check("sat_neg_const", 32'(r_a), 32'h0080);

    // Voice 2 never acks
    pl_a = 4'b1101; pr_a = 4'b1110;
    data_a = {16'h0002, 16'h4000, 16'h0010, 16'h0100}; dly = '{1, 1, 0, 3};
    run_frame("timeout");
    check("timeout_req2_len", 32'(req_cyc[2]), 32'd64);
    check("timeout_left_const", 32'(l_a), 32'h0201);
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0; exp_to = 1'b0;
    check("clear_tmo", 32'(to_a), 32'd0);
    check("clear_ovr", 32'(ovr_a), 32'd0);

    // Ack on the final timer cycle counts as an ack
    ven_a = 4'b0001; pl_a = 4'b0001; pr_a = 4'b0000;
    data_a = {48'h0, 16'h0123}; dly = '{64, 0, 0, 0};
    run_frame("ack_at_expiry");
    check("expiry_req0_len", 32'(req_cyc[0]), 32'd64);

    // Mixer disabled: silence still strobes
    en_a = 1'b0; ven_a = 4'b1111; pl_a = 4'b1111; pr_a = 4'b1111;
    data_a = {4{16'h1111}}; dly = '{1, 1, 1, 1};
    run_frame("disabled");
    check("disabled_no_req", 32'(first_req), 32'h0);

    // Negative sample, stray ack on a disabled voice, then output hold
    en_a = 1'b1; ven_a = 4'b0011; pl_a = 4'b1001; pr_a = 4'b1010; stray = 4'b1000;
    data_a = {16'h7FFF, 16'h0, 16'h0032, 16'hFF9C}; dly = '{1, 5, 0, 0};
    run_frame("stray");
    stray = 4'b0000;
    repeat (50) @(negedge clk);
    check("hold_left",  32'(l_a), 32'h9CFF);
    check("hold_right", 32'(r_a), 32'h3200);

    // Reset while voice 1 is being waited on
    ven_a = 4'b0010; dly = '{0, 0, 0, 0};
    got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      if (req_a[1]) got = 1'b1;
    end
    check("midwait_req1_seen", 32'(got), 32'd1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midwait_rst_req",   32'(req_a), 32'h0);
    check("midwait_rst_left",  32'(l_a), 32'h0);
    check("midwait_rst_right", 32'(r_a), 32'h0);
    check("midwait_rst_tmo",   32'(to_a), 32'h0);
    check("midwait_rst_ovr",   32'(ovr_a), 32'h0);
    exp_to = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ven_a = 4'b0011; pl_a = 4'b0001; pr_a = 4'b0001;
    data_a = {32'h0, 16'h0001, 16'h0042}; dly = '{2, 1, 0, 0};
    run_frame("post_reset");
    check("post_reset_first_req", 32'(first_req), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_voice_mixer.md
Name: audio_voice_mixer

Overview:
- Sequences the 48 kHz audio sample stream that feeds the I2S serializer on the Pocket.
- Derives the sample tick from clk_74a with a phase accumulator.
- Each tick, polls up to NUM_VOICES sound-effect generators in order (thrust, torpedo, explosion, etc.) through a req/ack handshake, then pans, sums, saturates and latches one left/right sample pair.
- Outputs drive left_audio/right_audio of the I2S serializer directly.

Parameters:
NUM_VOICES, 4, number of voice requesters (1..8)
TICK_INC, 48000, phase-accumulator increment per clock
TICK_MOD, 74250000, phase-accumulator modulus (clk_74a frequency in Hz)
TIMEOUT, 64, clocks to wait for voice_ack before the voice is treated as silent

Ports:
clk_74a  in  1  system clock, 74.25 MHz
reset_n  in  1  asynchronous active-low reset
enable  in  1  mixer enable; when low, frames output silence
voice_enable  in  NUM_VOICES  per-voice enable; disabled voices are skipped
pan_left  in  NUM_VOICES  voice i contributes to the left sum
pan_right  in  NUM_VOICES  voice i contributes to the right sum
voice_req  out  NUM_VOICES  one-hot sample request to voice i
voice_ack  in  NUM_VOICES  voice i presents valid data this cycle
voice_data  in  16*NUM_VOICES  signed sample; voice i at [16i+15:16i]
clear_flags  in  1  synchronous clear of sticky flags
left_audio  out  16  byte-swapped left sample
right_audio  out  16  byte-swapped right sample
sample_strobe  out  1  one-cycle pulse when a new pair is latched
overrun  out  1  sticky: a tick arrived while a frame was in progress
timeout_flag  out  1  sticky: a voice failed to ack within TIMEOUT

Behaviour:
- Reset (async, reset_n=0): all outputs are 0, phase accumulator is 0, FSM is IDLE, and all voice_req bits are low.

Tick generation:
- Each clock, next = phase + TICK_INC.
- If next >= TICK_MOD: phase <= next - TICK_MOD, and tick is 1 for one cycle. Otherwise phase <= next.
- The phase register is 32 bits.
- With defaults, the first tick comes 1547 clocks after reset release. The long-run rate is exactly 48000/s.

FSM states: IDLE, SCAN, WAIT, SAT.
- IDLE, tick:
  - enable=1: clear acc_l and acc_r (signed, 19 bits), idx <= 0, go to SCAN.
  - enable=0: go straight to SAT with acc_l = acc_r = 0. Silence is latched and sample_strobe still pulses.
- SCAN:
  - If voice_enable[idx]=1: voice_req[idx] <= 1, timer <= 0, go to WAIT.
  - Otherwise: advance idx. If idx==NUM_VOICES-1, go to SAT. Each skip costs 1 cycle.
- WAIT:
  - voice_ack[idx]=1 with voice_req[idx] high: voice_data[idx] is sampled on that cycle. It is sign-extended and added to acc_l if pan_left[idx], and to acc_r if pan_right[idx]. voice_req drops on the next cycle. Advance as in SCAN.
  - timer==TIMEOUT-1 without ack: drop req, set timeout_flag, add 0, advance.
  - Otherwise: timer increments.
- SAT: clamp each accumulator to [-32768, 32767]. Latch outputs as {s[7:0], s[15:8]}; the downstream serializer swaps bytes back. Pulse sample_strobe for one cycle, then return to IDLE.

Handshake rules:
- voice_req is one-hot or zero, and is held high until ack or timeout.
- voice_ack on a non-requested voice is ignored.
- An ack on the same cycle as timeout expiry counts as an ack; no flag is set.

Sticky flags:
- A tick in any state other than IDLE sets overrun, and the tick is dropped. The current frame completes normally.
- clear_flags clears both flags. If a set event occurs on the same cycle as clear_flags, the set wins.

Other boundary rules:
- enable or voice_enable changing mid-frame takes effect only for voices not yet visited. The current frame always completes.
- Outputs hold between strobes.
- Worst-case frame length is 2 + NUM_VOICES*(TIMEOUT+1) clocks. This must be below TICK_MOD/TICK_INC for overrun-free operation with the defaults.

Test Plan:
- Tick rate: TICK_INC=3, TICK_MOD=64. Over 640 clocks, exactly 30 ticks with phase wrap correct → 30 sample_strobe pulses with all voices disabled.
- Basic mix: voice0=0x1000 (pan L), voice1=0x0200 (pan L+R), both ack after 2 cycles → left_audio=0x0012, right_audio=0x0002 (byte-swapped 0x1200/0x0200); one strobe.
- Saturation:
  - Voices 0..3 = 0x7000, all pan L → left_audio=0xFF7F (0x7FFF).
  - All = 0x8000 → 0x0080 (0x8000).
- Timeout: voice2 never acks, TIMEOUT=64. req2 is high for exactly 64 cycles, then drops; timeout_flag=1; the sum excludes voice2. clear_flags then → 0.
- Overrun: TICK_MOD/TICK_INC=20, TIMEOUT=64, voice0 silent → overrun=1, frame completes, outputs updated once.
- Reset mid-WAIT: assert reset_n=0 while req1 is high → req, outputs and flags are 0 immediately. Next frame after release starts from idx 0.
